video_sig_gen: RTL
==================

Name: video_sig_gen

Overview:
- Raster timing generator for the 1280x720@60 video path. It produces per-pixel hcount/vcount, sync strobes, the active-draw flag, a new-frame pulse and a frame counter.
- It sits directly upstream of the fixed-latency delay stages. Those stages re-align hcount/vcount and syncs to image-processing latency before the HDMI/TMDS encoders.
- All outputs are registered and mutually consistent in the same cycle.

Parameters:
- ACTIVE_H, 1280: visible pixels per line
- H_FRONT, 110: horizontal front porch, in pixels
- H_SYNC, 40: horizontal sync width, in pixels
- H_BACK, 220: horizontal back porch, in pixels
- ACTIVE_V, 720: visible lines per frame
- V_FRONT, 5: vertical front porch, in lines
- V_SYNC, 5: vertical sync width, in lines
- V_BACK, 20: vertical back porch, in lines
- FPS, 60: frame-counter modulus

Ports:
- clk_in  input  1  pixel clock (74.25 MHz)
- rst_in  input  1  synchronous active-high reset
- hcount_out  output  $clog2(TOTAL_H) (11 at defaults)  current pixel column
- vcount_out  output  $clog2(TOTAL_V) (10 at defaults)  current line
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active-draw region flag
- nf_out  output  1  one-cycle new-frame pulse
- fc_out  output  $clog2(FPS) (6 at defaults)  frame count

Behaviour:
- Interface: one clock, clk_in. rst_in is synchronous and active-high.
- Derived constants:
  - TOTAL_H = ACTIVE_H+H_FRONT+H_SYNC+H_BACK (1650).
  - TOTAL_V = ACTIVE_V+V_FRONT+V_SYNC+V_BACK (750).
- Reset: while rst_in is high, all outputs are 0 at the next edge.
  - First cycle after release: hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0.
- hcount: increments by 1 every cycle. When hcount==TOTAL_H-1 it wraps to 0 on the next cycle.
- vcount: increments only on the cycle hcount wraps. When vcount==TOTAL_V-1 and hcount==TOTAL_H-1, it wraps to 0.
- hs_out: high exactly when ACTIVE_H+H_FRONT <= hcount < ACTIVE_H+H_FRONT+H_SYNC (1390..1429 at defaults).
- vs_out: high exactly when ACTIVE_V+V_FRONT <= vcount < ACTIVE_V+V_FRONT+V_SYNC (725..729 at defaults), for the whole line including blanking pixels.
- ad_out: high iff hcount<ACTIVE_H and vcount<ACTIVE_V.
- nf_out: high for exactly one cycle, on the cycle where hcount==ACTIVE_H and vcount==ACTIVE_V (start of vertical blank). It occurs exactly once per frame.
- fc_out: increments in the same cycle nf_out is high. It wraps from FPS-1 to 0.
- Output alignment: every flag is a function of the hcount/vcount values presented in the same cycle. No flag leads or lags its counters.
  - Implementation computes next-count and flags from next-count, then registers them all.
- Latency: zero cycles between the registered counters and the flags; all outputs share one register stage.
- Reset mid-frame: behaves exactly as the reset above. The frame restarts at (0,0) with fc=0, and no spurious nf pulse is produced.
- No enable input; the block free-runs whenever rst_in is low.

Decomposition:
- Shared package video_timing_pkg holds the 720p default timing constants, TOTAL_H/TOTAL_V, and the counter width localparams. Downstream delay stages size their BITS from these same constants.
- One sub-module is natural: wrap_counter, a parameterised modulus counter with synchronous reset, increment-enable and wrap-pulse output.
  - Instantiated three times: hcount (enable=1), vcount (enable=h wrap), fc (enable=nf).

Test Plan:
- Reset release: hold rst_in high for 3 cycles, release -> cycle 0 shows hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0. Cycle 1 shows hcount=1.
- Line wrap: run 1650 cycles -> hcount goes 1649 then 0, and vcount goes 0 to 1 in the same cycle as hcount=0. ad is high for hcount 0..1279 and low at 1280.
- Horizontal sync: within any line -> hs rises when hcount=1390 and falls when hcount=1430. Exactly 40 high cycles per line.
- Vertical sync and new frame: run one full frame of 1,237,500 cycles.
  - vs is high for all pixels of lines 725..729.
  - nf pulses exactly once, at (1280,720), and fc=1 on that cycle.
  - The next frame starts at (0,0).
- Frame counter wrap: run 60 frames -> fc reaches 59 then wraps to 0 on the 60th nf pulse. Exactly 60 nf pulses are seen.
- Mid-frame reset: assert rst_in at (hcount=500, vcount=300, fc=7) for 1 cycle -> next cycle all outputs 0, the following cycle is (0,0) with ad=1, and no nf pulse occurs until (1280,720).

Source files
------------

// File: rtl/video_timing_pkg.sv
// Purpose: shared 720p60 raster timing constants and counter widths for the video path.
// Latency: n/a (constants only).
// Backpressure: none; the raster free-runs, so downstream consumers can never stall it.
package video_timing_pkg;

  // 1280x720@60 defaults (74.25 MHz pixel clock).
  localparam int DEF_ACTIVE_H = 1280;
  localparam int DEF_H_FRONT  = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BACK   = 220;
  localparam int DEF_ACTIVE_V = 720;
  localparam int DEF_V_FRONT  = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BACK   = 20;
  localparam int DEF_FPS      = 60;

  // Full period of one raster axis: visible region plus all blanking.
  function automatic int raster_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int TOTAL_H = raster_total(DEF_ACTIVE_H, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int TOTAL_V = raster_total(DEF_ACTIVE_V, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // Widths shared with the downstream delay stages so their BITS track the raster.
  localparam int H_BITS  = $clog2(TOTAL_H);
  localparam int V_BITS  = $clog2(TOTAL_V);
  localparam int FC_BITS = $clog2(DEF_FPS);

endpackage

// File: rtl/wrap_counter.sv
// Purpose: modulus-MOD up counter with synchronous reset, increment enable and wrap flag.
// Latency: count is registered; next_count/wrap are combinational look-ahead of the next edge.
// Backpressure: none; en is a plain enable, not a handshake.
// Ports: clk_in/rst_in clock and sync active-high reset; en advances the count;
//        count current value; next_count value after the coming edge; wrap high when
//        the coming edge takes count from MOD-1 back to 0.
module wrap_counter #(
  parameter int MOD = 2,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] next_count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_comb begin
    wrap       = en && (count == LAST);
    next_count = count;
    if (wrap) begin
      next_count = '0;
    end else if (en) begin
      next_count = count + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// Purpose: raster timing generator (hcount/vcount, syncs, active-draw, new-frame, frame count).
// Latency: all outputs leave one shared register stage; flags always match the counters shown.
// Backpressure: none; free-runs whenever rst_in is low.
// Ports: clk_in pixel clock; rst_in sync active-high reset; hcount_out/vcount_out raster
//        position; hs_out/vs_out active-high syncs; ad_out active-draw; nf_out one-cycle
//        new-frame pulse at the start of vertical blank; fc_out frame count modulo FPS.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H = DEF_ACTIVE_H,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int ACTIVE_V = DEF_ACTIVE_V,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int FPS      = DEF_FPS,
  localparam int TOT_H   = raster_total(ACTIVE_H, H_FRONT, H_SYNC, H_BACK),
  localparam int TOT_V   = raster_total(ACTIVE_V, V_FRONT, V_SYNC, V_BACK),
  localparam int HW      = $clog2(TOT_H),
  localparam int VW      = $clog2(TOT_V),
  localparam int FW      = $clog2(FPS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out
);

  localparam logic [HW-1:0] H_ACT_END = HW'(ACTIVE_H);
  localparam logic [HW-1:0] HS_START  = HW'(ACTIVE_H + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(ACTIVE_H + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT_END = VW'(ACTIVE_V);
  localparam logic [VW-1:0] VS_START  = VW'(ACTIVE_V + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(ACTIVE_V + V_FRONT + V_SYNC);

  // Cleared by reset; the first edge after release presents (0,0) with its flags
  // instead of advancing, so reset shows all-zero and release shows pixel (0,0).
  logic running;

  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic [FW-1:0] fc_cnt, fc_next;
  logic          h_wrap;
  logic          v_wrap_unused;
  logic          fc_wrap_unused;
  logic          hs_next, vs_next, ad_next, nf_next;

  wrap_counter #(.MOD(TOT_H), .W(HW)) u_hcount (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (running),
    .count      (h_cnt),
    .next_count (h_next),
    .wrap       (h_wrap)
  );

  wrap_counter #(.MOD(TOT_V), .W(VW)) u_vcount (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (h_wrap),
    .count      (v_cnt),
    .next_count (v_next),
    .wrap       (v_wrap_unused)
  );

  // Advancing on nf_next lands the new frame count in the same cycle nf_out rises.
  wrap_counter #(.MOD(FPS), .W(FW)) u_fcount (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (nf_next),
    .count      (fc_cnt),
    .next_count (fc_next),
    .wrap       (fc_wrap_unused)
  );

  // Flags are decoded from the look-ahead counts so they register alongside them.
  always_comb begin
    hs_next = (h_next >= HS_START) && (h_next < HS_END);
    vs_next = (v_next >= VS_START) && (v_next < VS_END);
    ad_next = (h_next < H_ACT_END) && (v_next < V_ACT_END);
    nf_next = (h_next == H_ACT_END) && (v_next == V_ACT_END);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      running <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      ad_out  <= 1'b0;
      nf_out  <= 1'b0;
    end else begin
      running <= 1'b1;
      hs_out  <= hs_next;
      vs_out  <= vs_next;
      ad_out  <= ad_next;
      nf_out  <= nf_next;
    end
  end

  assign hcount_out = h_cnt;
  assign vcount_out = v_cnt;
  assign fc_out     = fc_cnt;

endmodule
